// File: rtl/pipelined_control_unit.sv
// Main control unit for a 5-stage RISC pipeline: decodes the ID opcode and
// carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
module pipelined_control_unit #(
  parameter int ALUOP_W     = 2,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               id_valid,
  input  logic               control_sel,
  input  logic               flush_ex,
  input  logic               stall_all,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_valid,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic               mem_valid,
  output logic               wb_memtoreg,
  output logic               wb_regwrite,
  output logic               wb_valid,
  output logic               ex_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  valid;
    logic  illegal;
  } id_ex_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
    logic branch;
    logic jump;
    logic valid;
  } ex_mem_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic valid;
  } mem_wb_t;

  ctrl_t            dec;
  logic             dec_illegal;
  logic             bubble;
  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0000000: dec = 9'b0_0_0_0_0_0_0_00;
      7'b0000011: dec = 9'b1_1_1_1_0_0_0_00;
      7'b0100011: dec = 9'b1_0_0_0_1_0_0_00;
      7'b0110011: dec = 9'b0_0_1_0_0_0_0_10;
      7'b0010011: dec = 9'b1_0_1_0_0_0_0_11;
      7'b1100011: dec = 9'b0_0_0_0_0_1_0_01;
      7'b1101111: begin
        if (ENABLE_JUMP) dec = 9'b0_0_1_0_0_0_1_00;
        else             dec_illegal = 1'b1;
      end
      7'b1100111: begin
        if (ENABLE_JUMP) dec = 9'b1_0_1_0_0_0_1_00;
        else             dec_illegal = 1'b1;
      end
      default:    dec_illegal = 1'b1;
    endcase
  end

  assign bubble = control_sel | ~id_valid | flush_ex;

  // A stall freezes every stage and the counter; bubble sources are ignored.
  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    cnt_d    = cnt_q;
    if (!stall_all) begin
      id_ex_d.ctrl    = bubble ? '0 : dec;
      id_ex_d.valid   = ~bubble;
      id_ex_d.illegal = ~bubble & dec_illegal;

      ex_mem_d.memread  = id_ex_q.ctrl.memread;
      ex_mem_d.memwrite = id_ex_q.ctrl.memwrite;
      ex_mem_d.memtoreg = id_ex_q.ctrl.memtoreg;
      ex_mem_d.regwrite = id_ex_q.ctrl.regwrite;
      ex_mem_d.branch   = id_ex_q.ctrl.branch;
      ex_mem_d.jump     = id_ex_q.ctrl.jump;
      ex_mem_d.valid    = id_ex_q.valid;

      mem_wb_d.memtoreg = ex_mem_q.memtoreg;
      mem_wb_d.regwrite = ex_mem_q.regwrite;
      mem_wb_d.valid    = ex_mem_q.valid;

      if (id_ex_d.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      cnt_q    <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_alusrc    = id_ex_q.ctrl.alusrc;
  assign ex_branch    = id_ex_q.ctrl.branch;
  assign ex_jump      = id_ex_q.ctrl.jump;
  assign ex_aluop     = ALUOP_W'(id_ex_q.ctrl.aluop);
  assign ex_valid     = id_ex_q.valid;
  assign ex_illegal   = id_ex_q.illegal;
  assign mem_memread  = ex_mem_q.memread;
  assign mem_memwrite = ex_mem_q.memwrite;
  assign mem_branch   = ex_mem_q.branch;
  assign mem_jump     = ex_mem_q.jump;
  assign mem_valid    = ex_mem_q.valid;
  assign wb_memtoreg  = mem_wb_q.memtoreg;
  assign wb_regwrite  = mem_wb_q.regwrite;
  assign wb_valid     = mem_wb_q.valid;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (jumps enabled / disabled)
// checked every cycle against a table-driven pipeline model plus literal checks.
module tb_pipelined_control_unit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_NOP = 7'b0000000, OP_LW  = 7'b0000011,
                         OP_SW  = 7'b0100011, OP_R   = 7'b0110011,
                         OP_I   = 7'b0010011, OP_BR  = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_JR  = 7'b1100111,
                         OP_BAD = 7'b1111111, OP_BD2 = 7'b0001011;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic       id_valid, control_sel, flush_ex, stall_all;

  logic             ex_alusrc [2], ex_branch [2], ex_jump [2], ex_valid [2];
  logic [1:0]       ex_aluop [2];
  logic             mem_memread [2], mem_memwrite [2], mem_branch [2], mem_jump [2], mem_valid [2];
  logic             wb_memtoreg [2], wb_regwrite [2], wb_valid [2];
  logic             ex_illegal [2];
  logic [CNT_W-1:0] illegal_cnt [2];

  int n_pass  = 0;
  int n_total = 0;

  // Instance 0 decodes jal/jalr, instance 1 treats them as illegal.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pipelined_control_unit #(
      .ALUOP_W(2), .ENABLE_JUMP(gi == 0 ? 1'b1 : 1'b0), .CNT_W(CNT_W)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .id_valid(id_valid),
      .control_sel(control_sel), .flush_ex(flush_ex), .stall_all(stall_all),
      .ex_alusrc(ex_alusrc[gi]), .ex_branch(ex_branch[gi]), .ex_jump(ex_jump[gi]),
      .ex_aluop(ex_aluop[gi]), .ex_valid(ex_valid[gi]),
      .mem_memread(mem_memread[gi]), .mem_memwrite(mem_memwrite[gi]),
      .mem_branch(mem_branch[gi]), .mem_jump(mem_jump[gi]), .mem_valid(mem_valid[gi]),
      .wb_memtoreg(wb_memtoreg[gi]), .wb_regwrite(wb_regwrite[gi]), .wb_valid(wb_valid[gi]),
      .ex_illegal(ex_illegal[gi]), .illegal_cnt(illegal_cnt[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Returns {illegal, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop[1:0]}.
  function automatic logic [9:0] decode(input logic [6:0] op, input bit ej);
    case (op)
      OP_NOP:  return 10'b0_000000000;
      OP_LW:   return 10'b0_111100000;
      OP_SW:   return 10'b0_100010000;
      OP_R:    return 10'b0_001000010;
      OP_I:    return 10'b0_101000011;
      OP_BR:   return 10'b0_000001001;
      OP_JAL:  return ej ? 10'b0_001000100 : 10'b1_000000000;
      OP_JR:   return ej ? 10'b0_101000100 : 10'b1_000000000;
      default: return 10'b1_000000000;
    endcase
  endfunction

  // Model stage contents.
  // ex : {alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,aluop[1:0],valid,illegal}
  // mem: {memread,memwrite,memtoreg,regwrite,branch,jump,valid}
  // wb : {memtoreg,regwrite,valid}
  logic [10:0] m_ex [2];
  logic [6:0]  m_mem [2];
  logic [2:0]  m_wb [2];
  int          m_cnt [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ex[k]  <= '0;
        m_mem[k] <= '0;
        m_wb[k]  <= '0;
        m_cnt[k] <= 0;
      end else if (!stall_all) begin
        logic [9:0] d;
        logic       bub;
        d   = decode(opcode, k == 0);
        bub = control_sel || !id_valid || flush_ex;
        m_ex[k]  <= bub ? 11'd0 : {d[8:0], 1'b1, d[9]};
        m_mem[k] <= {m_ex[k][7], m_ex[k][6], m_ex[k][9], m_ex[k][8],
                     m_ex[k][5], m_ex[k][4], m_ex[k][1]};
        m_wb[k]  <= {m_mem[k][4], m_mem[k][3], m_mem[k][0]};
        if (!bub && d[9] && m_cnt[k] < CNT_MAX) m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ex%0d", k),
            {25'd0, ex_alusrc[k], ex_branch[k], ex_jump[k], ex_aluop[k], ex_valid[k], ex_illegal[k]},
            {25'd0, m_ex[k][10], m_ex[k][5], m_ex[k][4], m_ex[k][3:2], m_ex[k][1], m_ex[k][0]});
      check($sformatf("mem%0d", k),
            {27'd0, mem_memread[k], mem_memwrite[k], mem_branch[k], mem_jump[k], mem_valid[k]},
            {27'd0, m_mem[k][6], m_mem[k][5], m_mem[k][2], m_mem[k][1], m_mem[k][0]});
      check($sformatf("wb%0d", k), {29'd0, wb_memtoreg[k], wb_regwrite[k], wb_valid[k]},
            {29'd0, m_wb[k]});
      check($sformatf("cnt%0d", k), 32'(illegal_cnt[k]), 32'(m_cnt[k]));
    end
  end

  task automatic drive(input logic [6:0] op, input logic v, input logic cs,
                       input logic fl, input logic st);
    opcode = op; id_valid = v; control_sel = cs; flush_ex = fl; stall_all = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic       prev_st, prev_fl, st, fl;
    rst_n = 1'b0; opcode = '0; id_valid = 0; control_sel = 0; flush_ex = 0; stall_all = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", 32'(ex_valid[0]), 0);
    check("rst_wb_valid", 32'(wb_valid[0]), 0);
    check("rst_cnt", 32'(illegal_cnt[0]), 0);
    rst_n = 1'b1;

    // lw through the pipe
    drive(OP_LW, 1, 0, 0, 0);
    check("lw_ex", {29'd0, ex_alusrc[0], ex_aluop[0]}, 32'b100);
    check("lw_ex_valid", 32'(ex_valid[0]), 1);
    idle();
    check("lw_mem_memread", 32'(mem_memread[0]), 1);
    idle();
    check("lw_wb", {29'd0, wb_memtoreg[0], wb_regwrite[0], wb_valid[0]}, 32'b111);

    // R, I, sw, branch back to back
    drive(OP_R, 1, 0, 0, 0);
    check("seq_aluop_r", 32'(ex_aluop[0]), 2);
    drive(OP_I, 1, 0, 0, 0);
    check("seq_aluop_i", 32'(ex_aluop[0]), 3);
    check("seq_memwrite_r", 32'(mem_memwrite[0]), 0);
    drive(OP_SW, 1, 0, 0, 0);
    check("seq_aluop_sw", 32'(ex_aluop[0]), 0);
    drive(OP_BR, 1, 0, 0, 0);
    check("seq_aluop_br", 32'(ex_aluop[0]), 1);
    check("seq_memwrite_sw", {30'd0, mem_memwrite[0], mem_branch[0]}, 32'b10);
    idle();
    check("seq_branch_br", {30'd0, mem_memwrite[0], mem_branch[0]}, 32'b01);

    // load-use bubble
    drive(OP_LW, 1, 0, 0, 0);
    drive(OP_R, 1, 1, 0, 0);
    check("bub_ex_valid", {29'd0, ex_valid[0], ex_alusrc[0], ex_aluop[0] != 0}, 0);
    drive(OP_R, 1, 0, 0, 0);
    check("bub_add_aluop", 32'(ex_aluop[0]), 2);
    check("bub_wb_rw_lw", 32'(wb_regwrite[0]), 1);
    idle();
    check("bub_wb_rw_bubble", 32'(wb_regwrite[0]), 0);
    idle();
    check("bub_wb_rw_add", 32'(wb_regwrite[0]), 1);

    // stall with a pending flush, sw alone in EX
    repeat (3) idle();
    drive(OP_SW, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(OP_R, 1, 0, 1, 1);
      check("stall_ex", {27'd0, ex_alusrc[0], ex_aluop[0], ex_valid[0], ex_illegal[0]}, 32'b10010);
      check("stall_later", {30'd0, mem_valid[0], wb_valid[0]}, 0);
    end
    drive(OP_R, 1, 0, 1, 0);
    check("flush_ex_valid", 32'(ex_valid[0]), 0);
    check("flush_mem_sw", 32'(mem_memwrite[0]), 1);

    // jal with and without jump decode
    drive(OP_JAL, 1, 0, 0, 0);
    check("jal_ex_jump", {30'd0, ex_jump[0], ex_jump[1]}, 32'b10);
    check("jal_illegal", {30'd0, ex_illegal[0], ex_illegal[1]}, 32'b01);
    check("jal_cnt_nj", 32'(illegal_cnt[1]), 1);
    check("jal_cnt_j", 32'(illegal_cnt[0]), 0);
    idle();
    idle();
    check("jal_wb_rw", {30'd0, wb_regwrite[0], wb_regwrite[1]}, 32'b10);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(OP_BAD, 1, 0, 0, 0);
      if (i == 253) check("sat_cnt_254", 32'(illegal_cnt[0]), 254);
    end
    check("sat_illegal", {30'd0, ex_illegal[0], ex_illegal[1]}, 32'b11);
    check("sat_cnt_j", 32'(illegal_cnt[0]), CNT_MAX);
    check("sat_cnt_nj", 32'(illegal_cnt[1]), CNT_MAX);

    // randomized traffic with a mid-stream asynchronous reset
    prev_st = 0; prev_fl = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        drive(OP_LW, 1, 0, 0, 0);
        drive(OP_R, 1, 0, 0, 0);
        drive(OP_LW, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          check("arst_valid", {29'd0, ex_valid[k], mem_valid[k], wb_valid[k]}, 0);
          check("arst_ctrl", {28'd0, ex_alusrc[k], mem_memread[k], wb_regwrite[k], wb_memtoreg[k]}, 0);
          check("arst_cnt", 32'(illegal_cnt[k]), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        prev_st = 0; prev_fl = 0;
      end else begin
        logic [6:0] ops [10];
        ops = '{OP_NOP, OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JR, OP_BAD, OP_BD2};
        st = ($urandom_range(0, 6) == 0);
        fl = (prev_st && prev_fl) ? 1'b1 : ($urandom_range(0, 7) == 0);
        drive(ops[$urandom_range(0, 9)], $urandom_range(0, 9) != 0,
              $urandom_range(0, 7) == 0, fl, st);
        prev_st = st; prev_fl = fl;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
